// File: rtl/move_pkg.sv
// ----------------------------------------------------------------------------
// move_pkg
// Shared definitions for the flash-to-memory mover (move_fsm_multi).
//  - One-hot state encodings (9 bits). ERR shares bit 8 with DONE and adds
//    bit 7, giving 9'h180.
//  - Default per-row word counts (length minus one) for SRAM and RAM rows.
//  - Helper identifying the states watched by the optional watchdog
//    (MOVE_TMO_EN).
// ----------------------------------------------------------------------------
package move_pkg;

    localparam int ST_W = 9;

    localparam logic [ST_W-1:0] ST_IDLE     = 9'h001;
    localparam logic [ST_W-1:0] ST_ROW_STA  = 9'h002;
    localparam logic [ST_W-1:0] ST_RD_REQ   = 9'h004;
    localparam logic [ST_W-1:0] ST_RD_WAIT  = 9'h008;
    localparam logic [ST_W-1:0] ST_RD_FLASH = 9'h010;
    localparam logic [ST_W-1:0] ST_WR_REQ   = 9'h020;
    localparam logic [ST_W-1:0] ST_WR_SRAM  = 9'h040;
    localparam logic [ST_W-1:0] ST_WR_RAM   = 9'h080;
    localparam logic [ST_W-1:0] ST_DONE     = 9'h100;
    localparam logic [ST_W-1:0] ST_ERR      = 9'h180;

    // Default row lengths, expressed as word count minus one.
    localparam int DEF_SRAM_LEN = 2069;
    localparam int DEF_RAM_LEN  = 1557;

    // States in which the mover waits on an external party (flash or SRAM).
    function automatic logic is_wait_state(input logic [ST_W-1:0] s);
        return (s == ST_RD_WAIT) || (s == ST_WR_SRAM);
    endfunction

endpackage

// File: rtl/move_edge_det.sv
// ----------------------------------------------------------------------------
// move_edge_det
// Registers flash_done through two flops and emits a one-cycle pulse on its
// falling edge (first flop low, second flop high).
// Ports:
//  clk          in  system clock
//  rst          in  synchronous active-high reset
//  flash_done_i in  raw flash row-ready level
//  fall_o       out one-cycle falling-edge pulse
// ----------------------------------------------------------------------------
module move_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic flash_done_i,
    output logic fall_o
);

    logic d1_q;
    logic d2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d1_q <= 1'b0;
            d2_q <= 1'b0;
        end else begin
            d1_q <= flash_done_i;
            d2_q <= d1_q;
        end
    end

    assign fall_o = ~d1_q & d2_q;

endmodule

// File: rtl/move_fsm_multi.sv
// ----------------------------------------------------------------------------
// move_fsm_multi
// Moves cfg_nrows consecutive flash rows starting at cfg_row0. Every row but
// the last is streamed into the SRAM write FIFO (SRAM address row<<ROW_SHIFT);
// the last row is streamed into on-chip RAM. done is raised at the end and
// held until enable drops. enable low aborts to IDLE from any state.
//
// Optional feature macro: MOVE_TMO_EN
//  defined   : watchdog counts cycles spent in RD_WAIT / WR_SRAM (cleared on
//              state entry); reaching TMO_CYC enters ERR (err=1, sticky until
//              enable low).
//  undefined : no watchdog, no ERR state, err tied to 0.
//
// Ports:
//  clk, rst                 clock, synchronous active-high reset
//  enable                   run level; low aborts to IDLE
//  flash_done               flash row-ready, falling edge = row available
//  empty                    SRAM FIFO empty
//  cfg_row0/cfg_nrows       first row / number of rows (>=1)
//  cfg_sram_len/cfg_ram_len words per SRAM/RAM row minus one
//  o_state                  one-hot state
//  busy, done, err          status
//  row                      current row
//  rd_req, rst_rfifo        flash request / read-FIFO flush (RSTF_CYC clk)
//  rd_en                    flash data read enable
//  wr_req                   one-cycle SRAM write request
//  fifo_wr, ram_wr          rd_en delayed one clock, SRAM / RAM rows
//  ram_addr                 RAM word address, valid with ram_wr
//  sram_waddr               SRAM word address of the current row
// ----------------------------------------------------------------------------
module move_fsm_multi
    import move_pkg::*;
#(
    parameter int ROW_W     = 14,
    parameter int ROW_SHIFT = 11,
    parameter int ADDR_W    = 24,
    parameter int CNT_W     = 12,
    parameter int RAM_AW    = 12,
    parameter int RSTF_CYC  = 2,
    parameter int TMO_CYC   = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              flash_done,
    input  logic              empty,
    input  logic [ROW_W-1:0]  cfg_row0,
    input  logic [ROW_W-1:0]  cfg_nrows,
    input  logic [CNT_W-1:0]  cfg_sram_len,
    input  logic [CNT_W-1:0]  cfg_ram_len,
    output logic [8:0]        o_state,
    output logic              busy,
    output logic              done,
    output logic [ROW_W-1:0]  row,
    output logic              rd_req,
    output logic              rd_en,
    output logic              rst_rfifo,
    output logic              wr_req,
    output logic              fifo_wr,
    output logic              ram_wr,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [ADDR_W-1:0] sram_waddr,
    output logic              err
);

    localparam logic [CNT_W-1:0] RSTF_LAST = CNT_W'(RSTF_CYC - 1);

    logic [ST_W-1:0]   state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Configuration snapshot taken on the IDLE -> ROW_STA transition.
    logic [ROW_W-1:0]  row0_q;
    logic [ROW_W-1:0]  last_row_q;
    logic [CNT_W-1:0]  sram_len_q;
    logic [CNT_W-1:0]  ram_len_q;

    logic              fifo_wr_q, fifo_wr_d;
    logic              ram_wr_q, ram_wr_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;

    logic              flash_fall;
    logic              cfg_load;

    move_edge_det u_edge (
        .clk          (clk),
        .rst          (rst),
        .flash_done_i (flash_done),
        .fall_o       (flash_fall)
    );

    assign cfg_load = enable && (state_q == ST_IDLE);

`ifdef MOVE_TMO_EN
    localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TMO_CYC != 0);
`endif

    // ------------------------------------------------------------------
    // State register (plus datapath registers that follow the FSM)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            cnt_q      <= '0;
            row0_q     <= '0;
            last_row_q <= '0;
            sram_len_q <= '0;
            ram_len_q  <= '0;
            fifo_wr_q  <= 1'b0;
            ram_wr_q   <= 1'b0;
            ram_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            fifo_wr_q  <= fifo_wr_d;
            ram_wr_q   <= ram_wr_d;
            ram_addr_q <= ram_addr_d;
            if (cfg_load) begin
                row0_q     <= cfg_row0;
                // Row arithmetic wraps modulo 2^ROW_W, so the last row does too.
                last_row_q <= cfg_row0 + cfg_nrows - 1'b1;
                sram_len_q <= cfg_sram_len;
                ram_len_q  <= cfg_ram_len;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;

        if (!enable) begin
            // Abort has priority over any edge/empty seen in the same cycle.
            state_d = ST_IDLE;
            row_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ROW_STA;
                    row_d   = '0;
                    cnt_d   = '0;
                end
                ST_ROW_STA: begin
                    row_d   = row0_q;
                    cnt_d   = '0;
                    state_d = ST_RD_REQ;
                end
                ST_RD_REQ: begin
                    if (cnt_q == RSTF_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_RD_WAIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RD_WAIT: begin
                    if (flash_fall) begin
                        cnt_d   = '0;
                        state_d = (row_q == last_row_q) ? ST_WR_RAM : ST_RD_FLASH;
                    end
                end
                ST_RD_FLASH: begin
                    if (cnt_q == sram_len_q) begin
                        cnt_d   = '0;
                        state_d = ST_WR_REQ;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WR_REQ: begin
                    state_d = ST_WR_SRAM;
                end
                ST_WR_SRAM: begin
                    if (empty) begin
                        row_d   = row_q + 1'b1;
                        state_d = ST_RD_REQ;
                    end
                end
                ST_WR_RAM: begin
                    if (cnt_q == ram_len_q) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
`ifdef MOVE_TMO_EN
                ST_ERR: begin
                    state_d = ST_ERR;
                end
`endif
                default: begin
                    // Any corrupted one-hot value recovers to IDLE.
                    state_d = ST_IDLE;
                    row_d   = '0;
                    cnt_d   = '0;
                end
            endcase

`ifdef MOVE_TMO_EN
            if (is_wait_state(state_q) && (state_d == state_q) && (tmo_q == TMO_LAST)) begin
                state_d = ST_ERR;
                cnt_d   = '0;
            end
`endif
        end
    end

`ifdef MOVE_TMO_EN
    // Watchdog counts only while staying in a wait state; any transition clears it.
    always_comb begin
        tmo_d = '0;
        if (is_wait_state(state_q) && (state_d == state_q)) begin
            tmo_d = tmo_q + 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        rd_req    = 1'b0;
        rst_rfifo = 1'b0;
        rd_en     = 1'b0;
        wr_req    = 1'b0;
        case (state_q)
            ST_RD_REQ: begin
                busy      = 1'b1;
                rd_req    = 1'b1;
                rst_rfifo = 1'b1;
            end
            ST_RD_WAIT:  busy = 1'b1;
            ST_RD_FLASH: begin
                busy  = 1'b1;
                rd_en = 1'b1;
            end
            ST_WR_REQ: begin
                busy   = 1'b1;
                wr_req = 1'b1;
            end
            ST_WR_SRAM:  busy = 1'b1;
            ST_WR_RAM: begin
                busy  = 1'b1;
                rd_en = 1'b1;
            end
            ST_DONE:     done = 1'b1;
`ifdef MOVE_TMO_EN
            ST_ERR:      err = 1'b1;
`endif
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Write strobes follow the flash read enable by one clock; the RAM address
    // is the word counter captured alongside ram_wr, so it reads 0 elsewhere.
    always_comb begin
        fifo_wr_d  = (state_q == ST_RD_FLASH);
        ram_wr_d   = (state_q == ST_WR_RAM);
        ram_addr_d = (state_q == ST_WR_RAM) ? RAM_AW'(cnt_q) : '0;
    end

    assign o_state    = state_q;
    assign row        = row_q;
    assign fifo_wr    = fifo_wr_q;
    assign ram_wr     = ram_wr_q;
    assign ram_addr   = ram_addr_q;
    // Shifting inside ADDR_W drops row bits above ADDR_W-ROW_SHIFT.
    assign sram_waddr = ADDR_W'(row_q) << ROW_SHIFT;

endmodule

// File: tb/tb_move_fsm_multi.sv
module tb_move_fsm_multi;
    import move_pkg::*;

    localparam int ROW_W  = 14;
    localparam int CNT_W  = 12;
    localparam int RAM_AW = 12;
    localparam int ADDR_W = 24;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              flash_done = 1'b1;
    logic              empty = 1'b0;
    logic [ROW_W-1:0]  cfg_row0 = '0;
    logic [ROW_W-1:0]  cfg_nrows = '0;
    logic [CNT_W-1:0]  cfg_sram_len = '0;
    logic [CNT_W-1:0]  cfg_ram_len = '0;
    logic [8:0]        o_state;
    logic              busy, done, rd_req, rd_en, rst_rfifo, wr_req;
    logic              fifo_wr, ram_wr, err;
    logic [ROW_W-1:0]  row;
    logic [RAM_AW-1:0] ram_addr;
    logic [ADDR_W-1:0] sram_waddr;

    always #5 clk = ~clk;

    move_fsm_multi #(.TMO_CYC(50)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .flash_done   (flash_done),
        .empty        (empty),
        .cfg_row0     (cfg_row0),
        .cfg_nrows    (cfg_nrows),
        .cfg_sram_len (cfg_sram_len),
        .cfg_ram_len  (cfg_ram_len),
        .o_state      (o_state),
        .busy         (busy),
        .done         (done),
        .row          (row),
        .rd_req       (rd_req),
        .rd_en        (rd_en),
        .rst_rfifo    (rst_rfifo),
        .wr_req       (wr_req),
        .fifo_wr      (fifo_wr),
        .ram_wr       (ram_wr),
        .ram_addr     (ram_addr),
        .sram_waddr   (sram_waddr),
        .err          (err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Per-run statistics gathered by tick().
    int row_fifo, tot_fifo, tot_ram, ram_idx, ram_addr_bad, last_ram_addr;
    int n_rdreq_cyc, n_rdreq_rise, n_rst_cyc, n_wrreq, wait_cnt, rdwait_cyc;
    bit rd_req_prev, flash_stuck;
    logic [31:0] waddr_q[$];
    int          rowfifo_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("vec %0d %s observed=0x%0h expected=0x%0h", n_vec, tag, obs, exp);
    endtask

    task automatic clear_stats();
        row_fifo = 0; tot_fifo = 0; tot_ram = 0; ram_idx = 0; ram_addr_bad = 0;
        last_ram_addr = -1; n_rdreq_cyc = 0; n_rdreq_rise = 0; n_rst_cyc = 0;
        n_wrreq = 0; wait_cnt = 0; rdwait_cyc = 0; rd_req_prev = 1'b0;
        waddr_q.delete(); rowfifo_q.delete();
    endtask

    // One clock: sample outputs #1 after the edge, update stats, then drive
    // the flash / SRAM FIFO models for the next cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (fifo_wr) begin row_fifo++; tot_fifo++; end
        if (ram_wr) begin
            if (ram_addr !== RAM_AW'(ram_idx)) ram_addr_bad++;
            last_ram_addr = int'(ram_addr);
            ram_idx++;
            tot_ram++;
        end
        if (rd_req) n_rdreq_cyc++;
        if (rd_req && !rd_req_prev) n_rdreq_rise++;
        rd_req_prev = rd_req;
        if (rst_rfifo) n_rst_cyc++;
        if (wr_req) begin
            n_wrreq++;
            waddr_q.push_back(32'(sram_waddr));
            rowfifo_q.push_back(row_fifo);
            row_fifo = 0;
        end
        if (o_state == ST_RD_WAIT) rdwait_cyc++;
        if (o_state == ST_RD_REQ) flash_done = 1'b1;
        else if (o_state == ST_RD_WAIT && !flash_stuck) flash_done = 1'b0;
        if (o_state == ST_WR_SRAM) begin
            wait_cnt++;
            empty = (wait_cnt >= 3);
        end else begin
            wait_cnt = 0;
            empty = 1'b0;
        end
    endtask

    task automatic run_to_end(input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick();
            if (done || err) hit = 1'b1;
        end
    endtask

    bit hit;
    int k;

    initial begin
        // ---------------- reset ----------------
        clear_stats();
        flash_stuck = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_state", 32'(o_state), 32'h001);
        chk("rst_flags", {23'd0, busy, done, rd_req, rd_en, rst_rfifo, wr_req, fifo_wr, ram_wr, err}, 32'd0);
        chk("rst_row", 32'(row), 32'd0);
        chk("rst_addr", {8'd0, sram_waddr}, 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        tick();
        chk("idle_hold", 32'(o_state), 32'h001);

        // ---------------- 4-row move, cfg changed mid-run ----------------
        clear_stats();
        cfg_row0 = 14'h800; cfg_nrows = 14'd4;
        cfg_sram_len = 12'(DEF_SRAM_LEN); cfg_ram_len = 12'(DEF_RAM_LEN);
        enable = 1'b1;
        tick();
        chk("start_rowsta", 32'(o_state), 32'h002);
        tick();
        chk("row_loaded", 32'(row), 32'h800);
        chk("rdreq_busy", {30'd0, busy, rd_req}, 32'h3);
        cfg_row0 = 14'h123; cfg_nrows = 14'd9; cfg_sram_len = 12'd5; cfg_ram_len = 12'd7;
        run_to_end(20000, hit);
        chk("main_finish", 32'(hit), 32'd1);
        chk("main_done", {30'd0, done, busy}, 32'h2);
        chk("main_fifo_tot", 32'(tot_fifo), 32'd6210);
        chk("main_row0_fifo", 32'(rowfifo_q[0]), 32'd2070);
        chk("main_row2_fifo", 32'(rowfifo_q[2]), 32'd2070);
        chk("main_wrreq", 32'(n_wrreq), 32'd3);
        chk("main_waddr0", waddr_q[0], 32'h400000);
        chk("main_waddr1", waddr_q[1], 32'h400800);
        chk("main_waddr2", waddr_q[2], 32'h401000);
        chk("main_ram_tot", 32'(tot_ram), 32'd1558);
        chk("main_ram_addr_seq", 32'(ram_addr_bad), 32'd0);
        chk("main_ram_last", 32'(last_ram_addr), 32'd1557);
        chk("main_row_last", 32'(row), 32'h803);
        chk("main_rdreq_cyc", 32'(n_rdreq_cyc), 32'd8);
        chk("main_rdreq_rows", 32'(n_rdreq_rise), 32'd4);
        chk("main_rstf_cyc", 32'(n_rst_cyc), 32'd8);
        tick();
        chk("done_held", 32'(o_state), 32'h100);
        enable = 1'b0;
        tick();
        chk("done_to_idle", 32'(o_state), 32'h001);
        chk("idle_clear", {22'd0, done, busy, row[7:0]}, 32'd0);

        // ---------------- single row: straight to RAM ----------------
        clear_stats();
        cfg_row0 = 14'h055; cfg_nrows = 14'd1;
        cfg_sram_len = 12'(DEF_SRAM_LEN); cfg_ram_len = 12'(DEF_RAM_LEN);
        enable = 1'b1;
        run_to_end(5000, hit);
        chk("one_finish", 32'(hit), 32'd1);
        chk("one_fifo", 32'(tot_fifo), 32'd0);
        chk("one_wrreq", 32'(n_wrreq), 32'd0);
        chk("one_ram_tot", 32'(tot_ram), 32'd1558);
        chk("one_ram_seq", 32'(ram_addr_bad), 32'd0);
        chk("one_rdreq_cyc", 32'(n_rdreq_cyc), 32'd2);
        chk("one_row", 32'(row), 32'h055);
        enable = 1'b0;
        tick();

        // ---------------- row wrap / address truncation ----------------
        clear_stats();
        cfg_row0 = 14'h3FFF; cfg_nrows = 14'd2; cfg_sram_len = 12'd3; cfg_ram_len = 12'd2;
        enable = 1'b1;
        run_to_end(500, hit);
        chk("wrap_finish", 32'(hit), 32'd1);
        chk("wrap_waddr", waddr_q[0], 32'hFFF800);
        chk("wrap_fifo", 32'(rowfifo_q[0]), 32'd4);
        chk("wrap_ram_tot", 32'(tot_ram), 32'd3);
        chk("wrap_ram_last", 32'(last_ram_addr), 32'd2);
        chk("wrap_row", 32'(row), 32'd0);
        enable = 1'b0;
        tick();

        // ---------------- abort in RD_FLASH at word 100 ----------------
        clear_stats();
        cfg_row0 = 14'h800; cfg_nrows = 14'd4;
        cfg_sram_len = 12'(DEF_SRAM_LEN); cfg_ram_len = 12'(DEF_RAM_LEN);
        enable = 1'b1;
        k = 0; hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            tick();
            if (rd_en) begin
                k++;
                if (k == 101) hit = 1'b1;
            end
        end
        chk("abort_reach", 32'(hit), 32'd1);
        enable = 1'b0;
        tick();
        chk("abort_state", 32'(o_state), 32'h001);
        chk("abort_rd_en", {30'd0, rd_en, busy}, 32'd0);
        chk("abort_fifo_lag", 32'(fifo_wr), 32'd1);
        chk("abort_row", 32'(row), 32'd0);
        tick();
        chk("abort_fifo_off", 32'(fifo_wr), 32'd0);

`ifdef MOVE_TMO_EN
        // ---------------- watchdog in RD_WAIT ----------------
        clear_stats();
        flash_stuck = 1'b1;
        flash_done = 1'b1;
        enable = 1'b1;
        run_to_end(500, hit);
        chk("tmo_trip", {30'd0, err, busy}, 32'h2);
        chk("tmo_state", 32'(o_state), 32'h180);
        chk("tmo_cycles", 32'(rdwait_cyc), 32'd50);
        enable = 1'b0;
        tick();
        chk("tmo_clear", {31'd0, err}, 32'd0);
        flash_stuck = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
